// File: rtl/alu_iter_mul.sv
// -----------------------------------------------------------------------------
// alu_iter_mul -- execution-stage ALU with an iterative shift-add multiplier.
//
// AND, OR, ADD, SUB and SLT are purely combinational. MUL (ALUControl 3'b101)
// runs one multiplier bit per cycle. Stall is held high while the product is
// being formed, and the product is presented for exactly one cycle together
// with a MulDone pulse.
//
// Ports:
//   CLK         in   core clock, rising edge
//   RST         in   asynchronous, active-high reset
//   SrcA        in   operand A (WIDTH bits)
//   SrcB        in   operand B (WIDTH bits)
//   ALUControl  in   3-bit operation code
//   InstrValid  in   instruction is real; a MUL only starts when high
//   ALUResult   out  result (WIDTH bits)
//   Zero        out  ALUResult == 0
//   Stall       out  hold PC / suppress register write this cycle
//   MulDone     out  one-cycle pulse while the MUL product is presented
//
// Optional build macro: MUL_EARLY_TERM_EN
//   When defined, the multiply ends as soon as the remaining multiplier bits
//   are all zero (a zero multiplier goes straight to DONE). Results are the
//   same either way; only the latency changes.
// -----------------------------------------------------------------------------
module alu_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  input  logic             InstrValid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Stall,
  output logic             MulDone
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_mul_done;

  logic             w_mul_req;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last_iter;
  logic [WIDTH-1:0] w_comb_res;

  assign w_mul_req  = (ALUControl == 3'b101) && InstrValid;
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set bits remain in the multiplier after this shift.
  assign w_last_iter = ((r_mplier >> 1) == {WIDTH{1'b0}});
`else
  assign w_last_iter = (r_cnt == CW'(WIDTH - 1));
`endif

  // Multiplier sequencer: latch operands, iterate, present the product once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_acc      <= {WIDTH{1'b0}};
      r_mcand    <= {WIDTH{1'b0}};
      r_mplier   <= {WIDTH{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_mul_done <= 1'b0;
    end else begin
      r_mul_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mul_req) begin
            r_mcand  <= SrcA;
            r_mplier <= SrcB;
            r_acc    <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
`ifdef MUL_EARLY_TERM_EN
            if (SrcB == {WIDTH{1'b0}}) begin
              r_state    <= S_DONE;
              r_mul_done <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
`else
            r_state <= S_BUSY;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last_iter) begin
            r_state    <= S_DONE;
            r_mul_done <= 1'b1;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_DONE: begin
          // Unconditional return so a still-held MUL is not re-issued.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Single-cycle operations; MUL and unused codes produce 0 here.
  always_comb begin
    w_comb_res = {WIDTH{1'b0}};
    case (ALUControl)
      3'b000:  w_comb_res = SrcA & SrcB;
      3'b001:  w_comb_res = SrcA | SrcB;
      3'b010:  w_comb_res = SrcA + SrcB;
      3'b100:  w_comb_res = SrcA - SrcB;
      3'b110:  w_comb_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: w_comb_res = {WIDTH{1'b0}};
    endcase
  end

  // Output steering by sequencer state; Stall is forced low during reset.
  always_comb begin
    ALUResult = w_comb_res;
    Stall     = 1'b0;
    case (r_state)
      S_BUSY: begin
        ALUResult = {WIDTH{1'b0}};
        Stall     = ~RST;
      end
      S_DONE: begin
        ALUResult = r_acc;
        Stall     = 1'b0;
      end
      default: begin
        ALUResult = w_comb_res;
        Stall     = w_mul_req & ~RST;
      end
    endcase
  end

  assign Zero    = (ALUResult == {WIDTH{1'b0}});
  assign MulDone = r_mul_done;

endmodule

// File: tb/tb_alu_iter_mul.sv
// -----------------------------------------------------------------------------
// Scoreboard testbench for alu_iter_mul. The driver pushes the expected result
// of every operation into a queue; a monitor on the falling edge pops and
// compares whenever the DUT presents a result (a single-cycle op, or MulDone).
// Products come from 64-bit arithmetic truncated to WIDTH; the expected number
// of stall cycles comes from the operand value.
// -----------------------------------------------------------------------------
module tb_alu_iter_mul;

  localparam int W = 32;

`ifdef MUL_EARLY_TERM_EN
  localparam int RST_AT = 2;
`else
  localparam int RST_AT = 10;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] srca, srcb;
  logic [2:0]   ctl;
  logic         valid;
  logic [W-1:0] alu_result;
  logic         zero, stall, mul_done;

  alu_iter_mul #(.WIDTH(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SrcA       (srca),
    .SrcB       (srcb),
    .ALUControl (ctl),
    .InstrValid (valid),
    .ALUResult  (alu_result),
    .Zero       (zero),
    .Stall      (stall),
    .MulDone    (mul_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_mul;
    logic [W-1:0] res;
    int           stalls;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   comb_active = 1'b0;
  int   stall_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour of the single-cycle operations.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return W'((64'(a) + 64'(b)) % (64'd1 << W));
      3'b100:  return W'((64'(a) + (64'd1 << W) - 64'(b)) % (64'd1 << W));
      3'b110:  return (sa < sb) ? W'(1) : W'(0);
      default: return W'(0);
    endcase
  endfunction

  // Number of cycles Stall is high for a MUL with multiplier b.
  function automatic int exp_stalls(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return 1 + n;
`else
    return W + 1;
`endif
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[W-1:0];
  endfunction

  // Monitor: count stall cycles, compare whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_cnt = 0;
    end else if (stall) begin
      stall_cnt++;
    end else if (mul_done || comb_active) begin
      if (q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check(e.is_mul ? "mul_result" : "comb_result", 64'(alu_result), 64'(e.res));
        check("zero_flag", 64'(zero), 64'(e.res == '0));
        check("muldone_flag", 64'(mul_done), 64'(e.is_mul));
        if (e.is_mul) check("mul_stall_cycles", 64'(stall_cnt), 64'(e.stalls));
      end
      stall_cnt = 0;
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mul_done) seen = 1'b1;
    end
    if (!seen) check("mul_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_comb(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic v);
    exp_t e;
    @(posedge clk); #1;
    ctl = op; srca = a; srcb = b; valid = v;
    comb_active = 1'b1;
    e.is_mul = 1'b0; e.res = ref_alu(op, a, b); e.stalls = 0;
    q.push_back(e);
  endtask

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(posedge clk); #1;
    ctl = 3'b101; srca = a; srcb = b; valid = 1'b1;
    comb_active = 1'b0;
    e.is_mul = 1'b1; e.res = ref_mul(a, b); e.stalls = exp_stalls(b);
    q.push_back(e);
    // Operand changes after the start cycle must not affect the product.
    @(posedge clk); #1;
    srca = $urandom; srcb = $urandom;
    wait_done();
  endtask

  initial begin
    exp_t e;
    logic [2:0] ops [6];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010;
    ops[3] = 3'b100; ops[4] = 3'b110; ops[5] = 3'b011;

    // Reset with a MUL request present: no stall, no done.
    rst = 1'b1; ctl = 3'b101; valid = 1'b1; srca = 32'd3; srcb = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_muldone", 64'(mul_done), 64'd0);
    ctl = 3'b000; valid = 1'b0;
    rst = 1'b0;

    // Directed single-cycle cases.
    do_comb(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    do_comb(3'b100, 32'd5, 32'd5, 1'b1);
    do_comb(3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1);
    do_comb(3'b110, 32'd1, 32'hFFFF_FFFF, 1'b1);
    do_comb(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    do_comb(3'b001, 32'hF000_0000, 32'h0000_000F, 1'b1);
    do_comb(3'b011, 32'h1234_5678, 32'h1111_1111, 1'b1);
    do_comb(3'b111, 32'h1234_5678, 32'h1111_1111, 1'b1);
    do_comb(3'b101, 32'd7, 32'd6, 1'b0);  // MUL without InstrValid: no start
    do_comb(3'b010, 32'd1, 32'd2, 1'b1);

    // Directed multiplies, including back-to-back.
    do_mul(32'd7, 32'd6);
    do_comb(3'b010, 32'd40, 32'd2, 1'b1);
    do_mul(32'hFFFF_FFFF, 32'd2);
    do_mul(32'h0001_0000, 32'h0001_0000);
    do_mul(32'd9, 32'd1);
    do_mul(32'd5, 32'd0);
    do_mul(32'd3, 32'd3);
    do_mul(32'd4, 32'd5);

    // Reset in the middle of MUL 3*4, request held through and after reset.
    @(posedge clk); #1;
    ctl = 3'b101; srca = 32'd3; srcb = 32'd4; valid = 1'b1; comb_active = 1'b0;
    repeat (RST_AT) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midmul_reset_stall", 64'(stall), 64'd0);
    check("midmul_reset_muldone", 64'(mul_done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    e.is_mul = 1'b1; e.res = 32'd12; e.stalls = exp_stalls(32'd4);
    q.push_back(e);
    rst = 1'b0;
    wait_done();

    // Randomized mix.
    for (int i = 0; i < 30; i++) begin
      do_comb(ops[$urandom_range(0, 5)], $urandom, $urandom, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      do_mul($urandom, $urandom >> $urandom_range(0, 31));
      do_comb(ops[$urandom_range(0, 5)], $urandom, $urandom, 1'b1);
    end

    @(posedge clk); #1;
    comb_active = 1'b0; ctl = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_iter_mul.md
Name: alu_iter_mul

Overview:
- Execution-stage ALU of the MIPS core. It consumes the 3-bit ALUControl code from the ALU decoder and the two operands from the register file / immediate mux.
- AND, OR, ADD, SUB and SLT complete combinationally in one cycle.
- MUL (ALUControl 3'b101) runs in an iterative shift-add multiplier. While it runs, the block asserts Stall so the PC and register-file write are held until the product is ready.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- CLK  input  1  core clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- ALUControl  input  3  operation code: 000 AND, 001 OR, 010 ADD, 100 SUB, 110 SLT, 101 MUL. Codes 011 and 111 are unused.
- InstrValid  input  1  current instruction is real. A MUL starts only when this is high.
- ALUResult  output  WIDTH  result.
- Zero  output  1  ALUResult == 0.
- Stall  output  1  hold PC and suppress register write this cycle.
- MulDone  output  1  one-cycle pulse in the cycle the MUL product is presented.

Behaviour:
- Reset: the single clock is CLK; reset RST is asynchronous and active-high.
  - State goes to IDLE; accumulator, multiplicand, multiplier and counter clear to 0.
  - Stall=0 and MulDone=0 while RST is high, regardless of inputs.
  - Reset mid-multiply aborts the operation with no result. After release, a still-present MUL request restarts from cycle 0.
- Combinational ops (any state other than BUSY/DONE, any code other than MUL):
  - AND/OR are bitwise.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT = 1 if $signed(SrcA) < $signed(SrcB), else 0, zero-extended.
  - Codes 011/111 give ALUResult=0.
  - Zero is always derived from the driven ALUResult.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If ALUControl==101 and InstrValid: Stall=1 combinationally, ALUResult=0. The clock edge latches SrcA into the multiplicand and SrcB into the multiplier, clears the accumulator and counter, and moves to BUSY.
  - If ALUControl==101 and InstrValid is low: Stall=0, ALUResult=0, no start.
- BUSY, one bit per cycle:
  - If multiplier[0]==1, the accumulator adds the multiplicand.
  - Multiplicand shifts left by 1; multiplier shifts right by 1 (logical); counter increments.
  - Arithmetic is truncated to WIDTH bits, so the result is the low WIDTH bits of the product (identical for signed and unsigned).
  - After the WIDTH-th iteration, move to DONE.
  - Stall=1 and ALUResult=0 throughout.
  - SrcA, SrcB and ALUControl changes are ignored.
- DONE, exactly one cycle:
  - Stall=0, MulDone=1, ALUResult = accumulator.
  - Next edge returns to IDLE unconditionally, so the same held MUL is not re-issued.
- Latency, without the optional feature: request in cycle 0, Stall high in cycles 0..WIDTH, result in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Back-to-back MULs: the second MUL's request is seen in the IDLE cycle after DONE and starts normally.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - BUSY moves to DONE after the iteration in which the shifted multiplier becomes 0.
  - A latched multiplier of 0 skips BUSY: IDLE goes to DONE, result 0 in cycle 1.
  - Latency = 1 + (index of highest set bit of SrcB + 1) cycles to DONE.
- Undefined: fixed WIDTH iterations as above. Results are identical either way.

Test Plan:
- ADD SrcA=0x7FFFFFFF, SrcB=1 -> ALUResult=0x80000000, Zero=0, Stall=0 same cycle. SUB 5-5 -> ALUResult=0, Zero=1.
- SLT SrcA=0xFFFFFFFF (-1), SrcB=1 -> 1. SLT SrcA=1, SrcB=0xFFFFFFFF -> 0.
- MUL 7*6 with InstrValid=1, macro off:
  - Stall=1 for cycles 0..32.
  - Cycle 33: ALUResult=42, MulDone=1, Stall=0.
  - Cycle 34: IDLE.
- MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE. MUL 0x10000*0x10000 -> 0, Zero=1 in DONE.
- Reset at cycle 10 of MUL 3*4 -> Stall=0 immediately. After release with the request held, result 12 arrives 33 cycles after release.
- Macro on: MUL 9*1 -> DONE at cycle 2 with result 9. MUL 5*0 -> DONE at cycle 1 with result 0.
